// File: rtl/instr_decode_queue.sv
// Instruction queue between fetch and execute with a combinational decode of the head entry.
// Optional feature macro: RV_M_EXT_EN (treats R-format func7 = 0000001, the MUL/DIV group, as legal).

module idq_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  fmt_e        fmt_c;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  always_comb begin
    fmt_c = FMT_NONE;
    case (opcode)
      7'b0110011:                                      fmt_c = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111,
      7'b1110011:                                      fmt_c = FMT_I;
      7'b0100011:                                      fmt_c = FMT_S;
      7'b1100011:                                      fmt_c = FMT_B;
      7'b0110111, 7'b0010111:                          fmt_c = FMT_U;
      7'b1101111:                                      fmt_c = FMT_J;
      default:                                         fmt_c = FMT_NONE;
    endcase
  end

  assign fmt = fmt_c;

  always_comb begin
    imm32 = '0;
    case (fmt_c)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries instr[31] in bit 31, so widening is a plain sign fill.
  always_comb begin
    imm = '0;
    if (fmt_c != FMT_R && fmt_c != FMT_NONE) begin
      imm       = {XLEN{instr[31]}};
      imm[31:0] = imm32;
    end
  end

  always_comb begin
    illegal = (fmt_c == FMT_NONE) || (instr[1:0] != 2'b11);
    if (fmt_c == FMT_R) begin
      case (func7)
        7'b0000000: ;
        7'b0100000: if (func3 != 3'b000 && func3 != 3'b101) illegal = 1'b1;
`ifdef RV_M_EXT_EN
        7'b0000001: ;
`else
        7'b0000001: illegal = 1'b1;
`endif
        default:    illegal = 1'b1;
      endcase
    end
    // Shift-right immediates: RV64 spends instr[25] on the 6-bit shamt.
    if (opcode == 7'b0010011 && func3 == 3'b101) begin
      if (XLEN == 32) begin
        if (instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000) illegal = 1'b1;
      end else begin
        if (instr[31:26] != 6'b000000 && instr[31:26] != 6'b010000) illegal = 1'b1;
      end
    end
  end
endmodule

module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop;
  logic [2:0]         dec_fmt;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_illegal;

  // in_ready looks only at occupancy, so a full queue never takes a word even while popping.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
  end

  assign head = mem[rd_ptr];

  idq_decode #(.XLEN(XLEN)) u_dec (
    .instr   (head.instr),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    out_pc      = '0;
    out_opcode  = '0;
    out_func3   = '0;
    out_func7   = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_fmt     = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_opcode  = head.instr[6:0];
      out_func3   = head.instr[14:12];
      out_func7   = head.instr[31:25];
      out_rs1     = head.instr[19:15];
      out_rs2     = head.instr[24:20];
      out_rd      = head.instr[11:7];
      out_fmt     = dec_fmt;
      out_imm     = dec_imm;
      out_illegal = dec_illegal;
    end
  end
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed plus random bench for instr_decode_queue against a queue-based reference model.
module tb_instr_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             in_ready, out_valid, out_illegal;
  logic [XLEN-1:0]  out_pc, out_imm;
  logic [6:0]       out_opcode, out_func7;
  logic [2:0]       out_func3, out_fmt;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [CNT_W-1:0] count;

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     w;
    logic [XLEN-1:0] pc;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the encoding tables, immediates assembled arithmetically.
  function automatic void ref_dec(input logic [31:0] w, output int fmt,
                                  output logic [63:0] imm, output bit ill);
    longint s, t;
    s = longint'($signed(w));
    case (w[6:0])
      7'h33:                             fmt = 0;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: fmt = 1;
      7'h23:                             fmt = 2;
      7'h63:                             fmt = 3;
      7'h37, 7'h17:                      fmt = 4;
      7'h6F:                             fmt = 5;
      default:                           fmt = 7;
    endcase
    imm = '0;
    case (fmt)
      1: imm = s >>> 20;
      2: begin t = s >>> 25; imm = t * 32 + w[11:7]; end
      3: begin t = s >>> 31; imm = t * 4096 + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2; end
      4: begin t = s >>> 12; imm = t * 4096; end
      5: begin t = s >>> 31; imm = t * 1048576 + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2; end
      default: imm = '0;
    endcase
    if (XLEN == 32) imm = imm & 64'hFFFF_FFFF;
    ill = (fmt == 7) || (w[1:0] != 2'b11);
    if (fmt == 0) begin
      if (w[31:25] == 7'h20)      ill = ill || !(w[14:12] == 3'd0 || w[14:12] == 3'd5);
      else if (w[31:25] == 7'h01) ill = ill || !M_EN;
      else if (w[31:25] != 7'h00) ill = 1'b1;
    end
    if (w[6:0] == 7'h13 && w[14:12] == 3'd5) begin
      if (XLEN == 32) ill = ill || !(w[31:25] == 7'h00 || w[31:25] == 7'h20);
      else            ill = ill || !(w[31:26] == 6'h00 || w[31:26] == 6'h10);
    end
  endfunction

  task automatic check_all();
    int          f;
    logic [63:0] im;
    bit          il;
    logic [31:0] w;
    logic [63:0] pc;
    f = 0; im = '0; il = 1'b0; w = '0; pc = '0;
    if (mq.size() != 0) begin
      w  = mq[0].w;
      pc = 64'(mq[0].pc);
      ref_dec(w, f, im, il);
    end
    chk("count",    64'(count),     64'(mq.size()));
    chk("in_ready", 64'(in_ready),  64'(mq.size() < DEPTH));
    chk("valid",    64'(out_valid), 64'(mq.size() != 0));
    chk("pc",       64'(out_pc),    pc);
    chk("opcode",   64'(out_opcode), 64'(w[6:0]));
    chk("func3",    64'(out_func3),  64'(w[14:12]));
    chk("func7",    64'(out_func7),  64'(w[31:25]));
    chk("rs1",      64'(out_rs1),    64'(w[19:15]));
    chk("rs2",      64'(out_rs2),    64'(w[24:20]));
    chk("rd",       64'(out_rd),     64'(w[11:7]));
    chk("fmt",      64'(out_fmt),    64'(f));
    chk("imm",      64'(out_imm),    im);
    chk("illegal",  64'(out_illegal), 64'(il));
  endtask

  // Drive one cycle, check pre-edge outputs, then advance the model across the edge.
  task automatic step(input bit iv, input logic [31:0] w, input logic [XLEN-1:0] pc,
                      input bit ordy, input bit fl);
    bit full, emp;
    in_valid = iv; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_all();
    @(posedge clk);
    full = (mq.size() >= DEPTH);
    emp  = (mq.size() == 0);
    if (!rst_n || fl) mq.delete();
    else begin
      if (ordy && !emp) mq.delete(0);
      if (iv && !full) mq.push_back('{w, pc});
    end
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 1) if (mq.size() != 0) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [6:0]  f7s [3];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    f7s = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    w[6:0] = ops[$urandom_range(11)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    if ($urandom_range(2) == 0) w[31:25] = f7s[$urandom_range(2)];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    step(1'b1, 32'h00500093, '0, 1'b0, 1'b0);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_fmt",   64'(out_fmt),   64'd1);
    chk("addi_rd",    64'(out_rd),    64'd1);
    chk("addi_rs1",   64'(out_rs1),   64'd0);
    chk("addi_imm",   64'(out_imm),   64'd5);
    chk("addi_ill",   64'(out_illegal), 64'd0);
    drain();

    step(1'b1, 32'hFE000EE3, XLEN'(4), 1'b0, 1'b0);
    chk("beq_fmt", 64'(out_fmt), 64'd3);
    chk("beq_imm", 64'(out_imm), (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0000_0000_FFFF_FFFC);
    drain();

    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, rand_instr(), XLEN'('h100 + 4 * i), 1'b0, 1'b0);
      chk("fill_ready", 64'(in_ready), 64'(i + 1 < DEPTH));
      chk("fill_count", 64'(count), 64'((i + 1 < DEPTH) ? i + 1 : DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk("fifo_pc", 64'(out_pc), 64'('h100 + 4 * i));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("fifo_empty", 64'(count), 64'd0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_instr(), XLEN'('h200 + 4 * i), 1'b0, 1'b0);
    step(1'b1, rand_instr(), XLEN'('h300), 1'b1, 1'b0);
    chk("fullpp_count", 64'(count), 64'(DEPTH - 1));
    chk("fullpp_ready", 64'(in_ready), 64'd1);
    step(1'b1, rand_instr(), XLEN'('h304), 1'b0, 1'b0);
    chk("wrap_count", 64'(count), 64'(DEPTH));
    for (int i = 1; i < DEPTH; i++) begin
      chk("wrap_pc", 64'(out_pc), 64'('h200 + 4 * i));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("wrap_last_pc", 64'(out_pc), 64'('h304));
    drain();

    for (int i = 0; i < 3; i++) step(1'b1, rand_instr(), XLEN'('h400 + 4 * i), 1'b0, 1'b0);
    step(1'b1, rand_instr(), XLEN'('h500), 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pc",    64'(out_pc), 64'd0);

    step(1'b1, 32'h02208033, XLEN'('h600), 1'b0, 1'b0);
    chk("mul_ill", 64'(out_illegal), 64'(!M_EN));
    drain();
    step(1'b1, 32'h00000000, XLEN'('h604), 1'b0, 1'b0);
    chk("zero_ill", 64'(out_illegal), 64'd1);
    chk("zero_fmt", 64'(out_fmt), 64'd7);
    drain();

    for (int i = 0; i < 2; i++) step(1'b1, rand_instr(), XLEN'('h700 + 4 * i), 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, rand_instr(), XLEN'('h800), 1'b1, 1'b1);
    rst_n = 1'b1;
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(3) != 0), rand_instr(), XLEN'($urandom) & ~XLEN'(3),
           1'($urandom_range(9) < 6), 1'($urandom_range(29) == 0));
    step(1'b0, '0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
